// File: rtl/sequenciador_pkg.sv
// Shared definitions for the two-requester UART packet sequencer:
// state encoding, byte index constants and default timeout sizing.
package sequenciador_pkg;

  localparam logic [2:0] ST_OCIOSO       = 3'd0;
  localparam logic [2:0] ST_CONCEDE      = 3'd1;
  localparam logic [2:0] ST_ESPERA_LIVRE = 3'd2;
  localparam logic [2:0] ST_INICIA       = 3'd3;
  localparam logic [2:0] ST_AGUARDA      = 3'd4;
  localparam logic [2:0] ST_PROXIMO      = 3'd5;
  localparam logic [2:0] ST_FINALIZA     = 3'd6;

  typedef enum logic [2:0] {
    OCIOSO       = ST_OCIOSO,
    CONCEDE      = ST_CONCEDE,
    ESPERA_LIVRE = ST_ESPERA_LIVRE,
    INICIA       = ST_INICIA,
    AGUARDA      = ST_AGUARDA,
    PROXIMO      = ST_PROXIMO,
    FINALIZA     = ST_FINALIZA
  } estado_t;

  localparam logic BYTE_CODIGO = 1'b0;
  localparam logic BYTE_VALOR  = 1'b1;

  localparam int TIMEOUT_CICLOS_PADRAO  = 65535;
  localparam int LARGURA_TIMEOUT_PADRAO = 16;

endpackage

// File: rtl/sequenciador_tx_arbitro.sv
// Two-way round-robin arbiter: combinational one-hot grant (bit0 = A, bit1 = B)
// and a pointer that, after each load, favours the side that was not granted.
module arbitro_rr2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       reqA,
  input  logic       reqB,
  input  logic       carrega,
  output logic [1:0] concessao,
  output logic       ponteiro
);

  logic       r_ponteiro;
  logic [1:0] w_concessao;

  always_comb begin
    w_concessao = 2'b00;
    if (reqA && reqB) begin
      w_concessao = r_ponteiro ? 2'b10 : 2'b01;
    end else if (reqA) begin
      w_concessao = 2'b01;
    end else if (reqB) begin
      w_concessao = 2'b10;
    end
  end

  // Pointer = 1 means B is favoured next time both request.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ponteiro <= 1'b0;
    end else if (carrega && (w_concessao != 2'b00)) begin
      r_ponteiro <= w_concessao[0];
    end
  end

  assign concessao = w_concessao;
  assign ponteiro  = r_ponteiro;

endmodule

// File: rtl/sequenciador_tx.sv
// Arbitrates requesters A and B for one uart_tx and sends each granted
// 2-byte packet (codigo, valor) through the start/done handshake.
module sequenciador_tx
  import sequenciador_pkg::*;
#(
  parameter int TIMEOUT_CICLOS  = TIMEOUT_CICLOS_PADRAO,
  parameter int LARGURA_TIMEOUT = LARGURA_TIMEOUT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reqA,
  input  logic [7:0] codigoA,
  input  logic [7:0] valorA,
  input  logic       reqB,
  input  logic [7:0] codigoB,
  input  logic [7:0] valorB,
  output logic       ackA,
  output logic       ackB,
  output logic       erroTimeout,
  output logic       ocupado,
  output logic       iniciaTx,
  output logic [7:0] byteTx,
  input  logic       txAtivo,
  input  logic       txConcluido
);

  estado_t                    r_estado;
  estado_t                    w_proximo;
  logic                       r_lado_b;
  logic [7:0]                 r_codigo;
  logic [7:0]                 r_valor;
  logic                       r_indice;
  logic [LARGURA_TIMEOUT-1:0] r_contador;
  logic                       r_aborta;
  logic [7:0]                 r_byte_tx;
  logic                       r_concluido_ant;

  logic [1:0] w_concessao;
  logic       w_ponteiro;
  logic       w_carrega;
  logic       w_borda;
  logic       w_timeout;

  assign w_carrega = (r_estado == OCIOSO) && (w_concessao != 2'b00);
  assign w_borda   = txConcluido && !r_concluido_ant;
  assign w_timeout = (r_contador == LARGURA_TIMEOUT'(TIMEOUT_CICLOS - 1));

  arbitro_rr2 u_arbitro (
    .clock     (clock),
    .reset     (reset),
    .reqA      (reqA),
    .reqB      (reqB),
    .carrega   (w_carrega),
    .concessao (w_concessao),
    .ponteiro  (w_ponteiro)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_comb begin
    w_proximo   = r_estado;
    iniciaTx    = 1'b0;
    ackA        = 1'b0;
    ackB        = 1'b0;
    erroTimeout = 1'b0;
    ocupado     = (r_estado != OCIOSO);
    case (r_estado)
      OCIOSO:       if (w_carrega) w_proximo = CONCEDE;
      CONCEDE:      w_proximo = ESPERA_LIVRE;
      ESPERA_LIVRE: if (!txAtivo && !txConcluido) w_proximo = INICIA;
      INICIA: begin
        iniciaTx  = 1'b1;
        w_proximo = AGUARDA;
      end
      // A done edge arriving on the timeout cycle still counts as success.
      AGUARDA: begin
        if (w_borda) begin
          w_proximo = PROXIMO;
        end else if (w_timeout) begin
          w_proximo = FINALIZA;
        end
      end
      PROXIMO:      w_proximo = (r_indice == BYTE_CODIGO) ? ESPERA_LIVRE : FINALIZA;
      FINALIZA: begin
        ackA        = !r_lado_b;
        ackB        = r_lado_b;
        erroTimeout = r_aborta;
        w_proximo   = OCIOSO;
      end
      default:      w_proximo = OCIOSO;
    endcase
  end

  // The pointer already moved to the non-granted side, so its inverse names the served side.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lado_b        <= 1'b0;
      r_codigo        <= 8'h00;
      r_valor         <= 8'h00;
      r_indice        <= BYTE_CODIGO;
      r_contador      <= '0;
      r_aborta        <= 1'b0;
      r_byte_tx       <= 8'h00;
      r_concluido_ant <= 1'b0;
    end else begin
      r_concluido_ant <= txConcluido;
      case (r_estado)
        CONCEDE: begin
          r_lado_b <= w_ponteiro ? 1'b0 : 1'b1;
          r_codigo <= w_ponteiro ? codigoA : codigoB;
          r_valor  <= w_ponteiro ? valorA : valorB;
          r_indice <= BYTE_CODIGO;
        end
        ESPERA_LIVRE: begin
          if (w_proximo == INICIA) begin
            r_byte_tx <= (r_indice == BYTE_CODIGO) ? r_codigo : r_valor;
          end
        end
        INICIA:   r_contador <= '0;
        AGUARDA: begin
          if (!w_borda && w_timeout) begin
            r_aborta <= 1'b1;
          end else begin
            r_contador <= r_contador + 1'b1;
          end
        end
        PROXIMO:  if (r_indice == BYTE_CODIGO) r_indice <= BYTE_VALOR;
        FINALIZA: r_aborta <= 1'b0;
        default: ;
      endcase
    end
  end

  assign byteTx = r_byte_tx;

endmodule
